sound_isa_dma_ctrl: RTL and testbench

Sequences ISA DMA cycles for the Sound Blaster DSP. It arbitrates the DSP's dma_req8/dma_req16 requests onto the two physical ISA channels, DMA1 (8-bit) and DMA5 (16-bit), and runs the DRQ/DACK/strobe handshake. It delivers each completed transfer to the DSP as a single-clock dma_ack with data. It sits between the ISA edge pins and the sound block's dma_* ports.

---
 rtl/sound_isa_dma_ctrl.sv | 152 +++++++++++++++
 tb/tb_sound_isa_dma_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sound_isa_dma_ctrl.sv
// sound_isa_dma_ctrl: runs ISA DMA1/DMA5 DRQ/DACK/strobe cycles for the DSP's 8/16-bit requests
// Ports: clk/rst; DSP side dma_req8/16, dma_16_en, dma_rec, dma_ack, dma_readdata, dma_writedata;
// ISA side drq1/drq5, dack1_n/dack5_n, ior_n/iow_n, tc (async), isa_din/isa_dout/isa_doe; tc_pulse.
module sound_isa_dma_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_req8,
  input  logic        dma_req16,
  input  logic        dma_16_en,
  input  logic        dma_rec,
  output logic        dma_ack,
  output logic [15:0] dma_readdata,
  input  logic [15:0] dma_writedata,
  output logic        drq1,
  output logic        drq5,
  input  logic        dack1_n,
  input  logic        dack5_n,
  input  logic        ior_n,
  input  logic        iow_n,
  input  logic        tc,
  input  logic [15:0] isa_din,
  output logic [15:0] isa_dout,
  output logic        isa_doe,
  output logic        tc_pulse
);
  typedef enum logic [2:0] {IDLE, REQ, ACK, STRB, DONE, GAP} state_t;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  state_t state_q, state_d;
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] s;
  logic ch5_q, ch5_d, split_q, split_d, rec_q, rec_d, g16_q, g16_d, phase_q, phase_d;
  logic tcs_q, tcs_d, drq_q, drq_d, ack_q, ack_d, tcp_q, tcp_d;
  logic [15:0] hold_q, hold_d, data_q, data_d, rd_q, rd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic dack_s, stb_s, req_on;
  // sync bit order {tc, iow_n, ior_n, dack5_n, dack1_n}; idle value has all strobes/dacks high
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'b01111;
    end else begin
      sync_q[0] <= {tc, iow_n, ior_n, dack5_n, dack1_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign s = sync_q[SYNC_STAGES-1];
  assign dack_s = ~(ch5_q ? s[1] : s[0]);
  assign stb_s = ~(rec_q ? s[2] : s[3]);
  // the request that won the grant must stay up, or the transfer is abandoned in REQ
  assign req_on = g16_q ? dma_req16 : dma_req8;
  always_comb begin
    state_d = state_q;
    ch5_d = ch5_q;
    split_d = split_q;
    rec_d = rec_q;
    g16_d = g16_q;
    phase_d = phase_q;
    tcs_d = tcs_q;
    drq_d = drq_q;
    hold_d = hold_q;
    data_d = data_q;
    rd_d = rd_q;
    gap_d = gap_q;
    ack_d = 1'b0;
    tcp_d = 1'b0;
    case (state_q)
      IDLE: if (gap_q == '0 && (dma_req16 || dma_req8)) begin
        state_d = REQ;
        g16_d = dma_req16;
        ch5_d = dma_req16 & dma_16_en;
        split_d = dma_req16 & ~dma_16_en;
        rec_d = dma_rec;
        hold_d = dma_writedata;
        phase_d = 1'b0;
        tcs_d = 1'b0;
        drq_d = 1'b1;
      end
      REQ: if (!req_on) begin
        state_d = IDLE;
        drq_d = 1'b0;
      end else if (dack_s) state_d = ACK;
      ACK: if (stb_s && dack_s) state_d = STRB;
      STRB: if (stb_s) begin
        data_d = rec_q ? data_q : isa_din;
        tcs_d = tcs_q | s[4];
      end else begin
        state_d = DONE;
        drq_d = 1'b0;
      end
      DONE: if (split_q && !phase_q) begin
        phase_d = 1'b1;
        rd_d = {rd_q[15:8], data_q[7:0]};
        drq_d = 1'b1;
        state_d = REQ;
      end else begin
        ack_d = 1'b1;
        tcp_d = tcs_q;
        rd_d = ch5_q ? data_q : split_q ? {data_q[7:0], rd_q[7:0]} : {8'h00, data_q[7:0]};
        gap_d = GW'(GAP_CYCLES);
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        state_d = (gap_q == GW'(1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch5_q <= 1'b0;
      split_q <= 1'b0;
      rec_q <= 1'b0;
      g16_q <= 1'b0;
      phase_q <= 1'b0;
      tcs_q <= 1'b0;
      drq_q <= 1'b0;
      ack_q <= 1'b0;
      tcp_q <= 1'b0;
      hold_q <= '0;
      data_q <= '0;
      rd_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      ch5_q <= ch5_d;
      split_q <= split_d;
      rec_q <= rec_d;
      g16_q <= g16_d;
      phase_q <= phase_d;
      tcs_q <= tcs_d;
      drq_q <= drq_d;
      ack_q <= ack_d;
      tcp_q <= tcp_d;
      hold_q <= hold_d;
      data_q <= data_d;
      rd_q <= rd_d;
      gap_q <= gap_d;
    end
  end
  assign drq1 = drq_q & ~ch5_q;
  assign drq5 = drq_q & ch5_q;
  assign dma_ack = ack_q;
  assign tc_pulse = tcp_q;
  assign dma_readdata = rd_q;
  // output enable uses the raw pins so the bus is driven as soon as the host asserts IOR
  assign isa_doe = ~(ch5_q ? dack5_n : dack1_n) & ~ior_n & rec_q & (state_q == ACK || state_q == STRB);
  assign isa_dout = ch5_q ? hold_q : {8'h00, (split_q && phase_q) ? hold_q[15:8] : hold_q[7:0]};
endmodule

// File: tb/tb_sound_isa_dma_ctrl.sv
// tb_sound_isa_dma_ctrl: table-driven, hand-written and random transfers checked against a transfer-level model
module tb_sound_isa_dma_ctrl;
  localparam int GAP = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic dma_req8 = 0, dma_req16 = 0, dma_16_en = 0, dma_rec = 0;
  logic dma_ack, drq1, drq5, isa_doe, tc_pulse;
  logic [15:0] dma_readdata, isa_dout;
  logic [15:0] dma_writedata = '0, isa_din = '0;
  logic dack1_n = 1, dack5_n = 1, ior_n = 1, iow_n = 1, tc = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, ack_cnt = 0, ack_cyc = 0;
  logic [15:0] ack_rd = '0;
  logic ack_tc = 0;
  typedef struct {
    logic r8, r16, en16, rec;
    logic [15:0] wd, d0, d1;
    logic t0, t1, x5;
    logic [15:0] xrd;
    logic xtc;
  } vec_t;
  vec_t tbl [8];
  always #5 clk = ~clk;
  sound_isa_dma_ctrl #(.SYNC_STAGES(2), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .dma_req8(dma_req8), .dma_req16(dma_req16), .dma_16_en(dma_16_en),
    .dma_rec(dma_rec), .dma_ack(dma_ack), .dma_readdata(dma_readdata), .dma_writedata(dma_writedata),
    .drq1(drq1), .drq5(drq5), .dack1_n(dack1_n), .dack5_n(dack5_n), .ior_n(ior_n), .iow_n(iow_n),
    .tc(tc), .isa_din(isa_din), .isa_dout(isa_dout), .isa_doe(isa_doe), .tc_pulse(tc_pulse)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dma_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
      ack_rd = dma_readdata;
      ack_tc = tc_pulse;
    end
    if (tc_pulse) chk("tc_with_ack", dma_ack, 1);
  end
  function automatic logic [15:0] m_rd(input vec_t v);
    if (v.r16 && v.en16) return v.d0;
    if (v.r16) return {v.d1[7:0], v.d0[7:0]};
    return {8'h00, v.d0[7:0]};
  endfunction
  function automatic logic [15:0] m_dout(input logic ch5, input logic ph, input logic [15:0] wd);
    if (ch5) return wd;
    return ph ? {8'h00, wd[15:8]} : {8'h00, wd[7:0]};
  endfunction
  task automatic wait_drq(input logic ch5);
    logic ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = ch5 ? drq5 : drq1;
    end
    chk(ch5 ? "drq5_wait" : "drq1_wait", ok, 1);
    chk("other_drq_low", ch5 ? drq1 : drq5, 0);
  endtask
  task automatic byte_cycle(input logic ch5, input logic rec, input logic [15:0] din, input logic tcv, input logic [15:0] xdout);
    wait_drq(ch5);
    if (ch5) dack5_n = 0; else dack1_n = 0;
    repeat (3) @(negedge clk);
    if (rec) chk("doe_no_strobe", isa_doe, 0);
    isa_din = din;
    tc = tcv;
    if (rec) ior_n = 0; else iow_n = 0;
    #1 chk("doe_strobe", isa_doe, rec);
    if (rec) chk("isa_dout", isa_dout, xdout);
    repeat (3) @(negedge clk);
    ior_n = 1; iow_n = 1; dack1_n = 1; dack5_n = 1; tc = 0;
    #1 chk("doe_release", isa_doe, 0);
    repeat (3) @(negedge clk);
    chk("drq_low_done", ch5 ? drq5 : drq1, 0);
    isa_din = 16'($urandom);
  endtask
  task automatic wait_ack(input int base, input logic [15:0] xrd, input logic chkrd, input logic xtc);
    for (int k = 0; k < 20 && ack_cnt == base; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("ack_count", ack_cnt - base, 1);
    if (chkrd) chk("readdata", ack_rd, xrd);
    chk("tc_pulse", ack_tc, xtc);
  endtask
  task automatic run(input vec_t v);
    int base = ack_cnt;
    logic split = v.r16 & ~v.en16;
    dma_req8 = v.r8; dma_req16 = v.r16; dma_16_en = v.en16; dma_rec = v.rec; dma_writedata = v.wd;
    byte_cycle(v.x5, v.rec, v.d0, v.t0, m_dout(v.x5, 0, v.wd));
    if (split) byte_cycle(0, v.rec, v.d1, v.t1, m_dout(0, 1, v.wd));
    wait_ack(base, v.xrd, ~v.rec, v.xtc);
    dma_req8 = 0; dma_req16 = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int base;
    int r;
    vec_t v;
    tbl[0] = '{1, 0, 1, 0, 16'h0000, 16'h12A5, 16'h0000, 0, 0, 0, 16'h00A5, 0};
    tbl[1] = '{0, 1, 1, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 1, 16'hBEEF, 0};
    tbl[2] = '{0, 1, 0, 0, 16'h0000, 16'h7734, 16'hAB12, 0, 0, 0, 16'h1234, 0};
    tbl[3] = '{0, 1, 0, 1, 16'hCAFE, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 1};
    tbl[4] = '{1, 1, 1, 0, 16'h0000, 16'h0F0F, 16'h0000, 1, 0, 1, 16'h0F0F, 1};
    tbl[5] = '{0, 1, 0, 0, 16'h0000, 16'hC355, 16'h99AA, 1, 0, 0, 16'hAA55, 1};
    tbl[6] = '{1, 0, 0, 0, 16'h0000, 16'h3399, 16'h0000, 1, 0, 0, 16'h0099, 1};
    tbl[7] = '{0, 1, 1, 1, 16'h1357, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 0};
    repeat (3) @(negedge clk);
    chk("rst_drq1", drq1, 0); chk("rst_drq5", drq5, 0); chk("rst_ack", dma_ack, 0);
    chk("rst_doe", isa_doe, 0); chk("rst_tc", tc_pulse, 0); chk("rst_rd", dma_readdata, 0);
    chk("rst_dout", isa_dout, 0);
    rst = 0;
    for (int i = 0; i < 8; i++) run(tbl[i]);
    // back-to-back DMA5: spacing from dma_ack to next DRQ, then abort before DACK
    base = ack_cnt;
    dma_req16 = 1; dma_16_en = 1; dma_rec = 0;
    byte_cycle(1, 0, 16'hBEEF, 0, 0);
    wait_ack(base, 16'hBEEF, 1, 0);
    wait_drq(1);
    r = cyc;
    chk("gap_len", r - ack_cyc, GAP + 1);
    dma_req16 = 0;
    @(negedge clk);
    chk("abort_drq5", drq5, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_ack", ack_cnt - base, 1);
    // reset in STRB of a record transfer, then re-grant of the still-pending request
    base = ack_cnt;
    dma_req8 = 1; dma_16_en = 1; dma_rec = 1; dma_writedata = 16'h5A3C;
    wait_drq(0);
    dack1_n = 0;
    repeat (3) @(negedge clk);
    ior_n = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_doe", isa_doe, 1); chk("pre_rst_dout", isa_dout, 16'h003C);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_drq1", drq1, 0); chk("mid_rst_drq5", drq5, 0); chk("mid_rst_ack", dma_ack, 0);
    chk("mid_rst_doe", isa_doe, 0); chk("mid_rst_tc", tc_pulse, 0); chk("mid_rst_rd", dma_readdata, 0);
    chk("mid_rst_dout", isa_dout, 0);
    ior_n = 1; dack1_n = 1;
    @(negedge clk);
    rst = 0;
    byte_cycle(0, 1, 16'h0000, 1, 16'h003C);
    wait_ack(base, 16'h0000, 0, 1);
    dma_req8 = 0;
    for (int i = 0; i < 30; i++) begin
      v.r16 = 1'($urandom); v.r8 = ~v.r16 | 1'($urandom); v.en16 = 1'($urandom); v.rec = 1'($urandom);
      v.wd = 16'($urandom); v.d0 = 16'($urandom); v.d1 = 16'($urandom);
      v.t0 = 1'($urandom); v.t1 = 1'($urandom);
      v.x5 = v.r16 & v.en16;
      v.xrd = m_rd(v);
      v.xtc = v.t0 | (v.r16 & ~v.en16 & v.t1);
      run(v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
